// File: rtl/product_result_buffer.sv
// ---------------------------------------------------------------------------
// product_result_buffer
//   Registered output stage for the 16-bit (1/8/7) floating-point multiplier.
//   Each Product word is captured under a valid/ready handshake, classified
//   (zero / subnormal / normal / inf / NaN), and queued in a small FIFO.
//   Saturating per-class statistics are kept for debug and precision tuning.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/ready    upstream handshake; in_product = {sign, exp[7:0], mant[6:0]}
//   out_valid/ready   downstream handshake for the head entry
//   out_product       head entry word
//   out_class         head entry class: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 NaN
//   level             current occupancy, 0..DEPTH
//   clr_stats         synchronous clear of the statistics counters
//   cnt_zero/inf/nan  saturating counts of accepted zero / inf / NaN words
// ---------------------------------------------------------------------------
module product_result_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_product,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_product,
    output logic [2:0]                 out_class,
    output logic [$clog2(DEPTH+1)-1:0] level,
    input  logic                       clr_stats,
    output logic [CNT_W-1:0]           cnt_zero,
    output logic [CNT_W-1:0]           cnt_inf,
    output logic [CNT_W-1:0]           cnt_nan
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } cls_e;

    logic [15:0]      data_q [DEPTH];
    cls_e             cls_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic [15:0]      head_prod_q, head_prod_d;
    cls_e             head_cls_q,  head_cls_d;
    logic [CNT_W-1:0] cnt_zero_q, cnt_zero_d;
    logic [CNT_W-1:0] cnt_inf_q,  cnt_inf_d;
    logic [CNT_W-1:0] cnt_nan_q,  cnt_nan_d;

    cls_e             in_cls;
    logic             accept;
    logic             take;

    // Classification ignores the sign bit.
    always_comb begin
        in_cls = CLS_NORM;
        if (in_product[14:7] == 8'h00) begin
            in_cls = (in_product[6:0] == 7'd0) ? CLS_ZERO : CLS_SUB;
        end else if (in_product[14:7] == 8'hFF) begin
            in_cls = (in_product[6:0] == 7'd0) ? CLS_INF : CLS_NAN;
        end
    end

    // Ready depends on registered occupancy only: a full buffer refuses a
    // push even in a cycle where the head is being taken.
    assign in_ready  = !rst && (level_q < LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;

    always_comb begin
        wr_ptr_d    = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = take   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        unique case ({accept, take})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // The head register is preloaded with the entry the read pointer will
        // point at next. The write and next-read pointers only coincide during
        // an accept when the buffer is (or becomes) empty, in which case the
        // incoming word is the next head. With nothing left, the last head holds.
        head_prod_d = head_prod_q;
        head_cls_d  = head_cls_q;
        if (level_d != '0) begin
            if (accept && (wr_ptr_q == rd_ptr_d)) begin
                head_prod_d = in_product;
                head_cls_d  = in_cls;
            end else begin
                head_prod_d = data_q[rd_ptr_d];
                head_cls_d  = cls_q[rd_ptr_d];
            end
        end

        // Clear wins over the stored count but not over a coincident accept.
        cnt_zero_d = clr_stats ? '0 : cnt_zero_q;
        cnt_inf_d  = clr_stats ? '0 : cnt_inf_q;
        cnt_nan_d  = clr_stats ? '0 : cnt_nan_q;
        if (accept) begin
            unique case (in_cls)
                CLS_ZERO: if (cnt_zero_d != '1) cnt_zero_d = cnt_zero_d + CNT_W'(1);
                CLS_INF:  if (cnt_inf_d  != '1) cnt_inf_d  = cnt_inf_d  + CNT_W'(1);
                CLS_NAN:  if (cnt_nan_d  != '1) cnt_nan_d  = cnt_nan_d  + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage array carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q[wr_ptr_q] <= in_product;
            cls_q[wr_ptr_q]  <= in_cls;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            head_prod_q <= '0;
            head_cls_q  <= CLS_ZERO;
            cnt_zero_q  <= '0;
            cnt_inf_q   <= '0;
            cnt_nan_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            head_prod_q <= head_prod_d;
            head_cls_q  <= head_cls_d;
            cnt_zero_q  <= cnt_zero_d;
            cnt_inf_q   <= cnt_inf_d;
            cnt_nan_q   <= cnt_nan_d;
        end
    end

    assign out_product = head_prod_q;
    assign out_class   = head_cls_q;
    assign level       = level_q;
    assign cnt_zero    = cnt_zero_q;
    assign cnt_inf     = cnt_inf_q;
    assign cnt_nan     = cnt_nan_q;

endmodule

// File: tb/tb_product_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_product_result_buffer
//   Scoreboard bench: every accepted word is queued with its expected class,
//   every taken head entry is popped and compared. Scenario tasks check
//   occupancy, handshake and statistics inline.
// ---------------------------------------------------------------------------
module tb_product_result_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_product = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [15:0]       out_product;
    logic [2:0]        out_class;
    logic [2:0]        level;
    logic              clr_stats = 1'b0;
    logic [CNT_W-1:0]  cnt_zero;
    logic [CNT_W-1:0]  cnt_inf;
    logic [CNT_W-1:0]  cnt_nan;

    int checks = 0;
    int errors = 0;
    int npop   = 0;

    logic [18:0] sb [$];
    logic [18:0] ent;
    logic [15:0] words [4];

    always #5 clk = ~clk;

    product_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_product  (in_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_class   (out_class),
        .level       (level),
        .clr_stats   (clr_stats),
        .cnt_zero    (cnt_zero),
        .cnt_inf     (cnt_inf),
        .cnt_nan     (cnt_nan)
    );

    function automatic logic [2:0] cls_of(input logic [15:0] w);
        if (w[14:7] == 8'h00) return (w[6:0] == 7'd0) ? 3'd0 : 3'd1;
        if (w[14:7] == 8'hFF) return (w[6:0] == 7'd0) ? 3'd3 : 3'd4;
        return 3'd2;
    endfunction

    // Reset discards everything the buffer held.
    always @(posedge rst) sb.delete();

    // Scoreboard: inputs are stable between the #1-after-posedge drive point
    // and the next posedge, so the negedge sees exactly what the edge will do.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) sb.push_back({cls_of(in_product), in_product});
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pop_underflow: got %h/%0d, expected no entry", out_product, out_class);
                end else begin
                    ent = sb.pop_front();
                    npop++;
                    if ({out_class, out_product} !== ent) begin
                        errors++;
                        $display("FAIL pop_data: got %h class %0d, expected %h class %0d",
                                 out_product, out_class, ent[15:0], ent[18:16]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && level != 0; i++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 9;
        if (level !== 3'd0)       begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
        if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        if (in_ready !== 1'b0)    begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        if (out_product !== 16'h0) begin errors++; $display("FAIL rst_out_product: got %h expected 0000", out_product); end
        if (out_class !== 3'd0)   begin errors++; $display("FAIL rst_out_class: got %0d expected 0", out_class); end
        if (cnt_zero !== 4'd0)    begin errors++; $display("FAIL rst_cnt_zero: got %0d expected 0", cnt_zero); end
        if (cnt_inf !== 4'd0)     begin errors++; $display("FAIL rst_cnt_inf: got %0d expected 0", cnt_inf); end
        if (cnt_nan !== 4'd0)     begin errors++; $display("FAIL rst_cnt_nan: got %0d expected 0", cnt_nan); end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        if (in_ready !== 1'b1)    begin errors++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_fill_drain();
        words[0] = 16'h3F80; words[1] = 16'h0000; words[2] = 16'h7F80; words[3] = 16'h7FC1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_product = words[0];
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL no_comb_path: got out_valid %b expected 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_product !== 16'h3F80 || out_class !== 3'd2) begin
            errors++;
            $display("FAIL first_latency: got v=%b %h class %0d expected v=1 3f80 class 2", out_valid, out_product, out_class);
        end
        for (int i = 1; i < 4; i++) begin
            in_product = words[i];
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (level !== 3'd4)    begin errors++; $display("FAIL fill_level: got %0d expected 4", level); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
        drain();
        @(negedge clk);
        checks += 4;
        if (level !== 3'd0)    begin errors++; $display("FAIL drain_level: got %0d expected 0", level); end
        if (cnt_zero !== 4'd1) begin errors++; $display("FAIL fill_cnt_zero: got %0d expected 1", cnt_zero); end
        if (cnt_inf !== 4'd1)  begin errors++; $display("FAIL fill_cnt_inf: got %0d expected 1", cnt_inf); end
        if (cnt_nan !== 4'd1)  begin errors++; $display("FAIL fill_cnt_nan: got %0d expected 1", cnt_nan); end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_product = 16'h4000 + 16'(i);
            tick();
        end
        in_product = 16'h4100;
        out_ready  = 1'b1;
        @(negedge clk);
        checks += 2;
        if (level !== 3'd4)    begin errors++; $display("FAIL full_level: got %0d expected 4", level); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_refuse: got in_ready %b expected 0", in_ready); end
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        checks += 2;
        if (level !== 3'd3)    begin errors++; $display("FAIL full_pop_level: got %0d expected 3", level); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (level !== 3'd4)    begin errors++; $display("FAIL full_repush_level: got %0d expected 4", level); end
        drain();
        @(negedge clk);
        checks += 2;
        if (level !== 3'd0)    begin errors++; $display("FAIL full_drain_level: got %0d expected 0", level); end
        if (cnt_zero !== 4'd1 || cnt_inf !== 4'd1 || cnt_nan !== 4'd1) begin
            errors++;
            $display("FAIL full_counters: got %0d/%0d/%0d expected 1/1/1", cnt_zero, cnt_inf, cnt_nan);
        end
    endtask

    task automatic test_back_to_back();
        int npop0;
        npop0     = npop;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_product = 16'h4200 + 16'(i);
            tick();
            @(negedge clk);
            checks++;
            if (level !== 3'd1) begin errors++; $display("FAIL stream_level[%0d]: got %0d expected 1", i, level); end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        checks += 2;
        if (level !== 3'd0)      begin errors++; $display("FAIL stream_end_level: got %0d expected 0", level); end
        if (npop - npop0 != 20)  begin errors++; $display("FAIL stream_pops: got %0d expected 20", npop - npop0); end
    endtask

    task automatic test_classify();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_product = 16'h0041;
        tick();
        checks++;
        if (out_class !== 3'd1) begin errors++; $display("FAIL class_subnormal: got %0d expected 1", out_class); end
        in_product = 16'h8000;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (level !== 3'd2) begin errors++; $display("FAIL class_level: got %0d expected 2", level); end
        drain();
        @(negedge clk);
        checks += 3;
        if (cnt_zero !== 4'd2) begin errors++; $display("FAIL class_cnt_zero: got %0d expected 2", cnt_zero); end
        if (cnt_inf !== 4'd1)  begin errors++; $display("FAIL class_cnt_inf: got %0d expected 1", cnt_inf); end
        if (cnt_nan !== 4'd1)  begin errors++; $display("FAIL class_cnt_nan: got %0d expected 1", cnt_nan); end
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_product = {i[0], 8'hFF, 7'h01 + 7'(i)};
            tick();
        end
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        checks += 2;
        if (cnt_nan !== 4'd15) begin errors++; $display("FAIL sat_cnt_nan: got %0d expected 15", cnt_nan); end
        if (cnt_zero !== 4'd2) begin errors++; $display("FAIL sat_cnt_zero: got %0d expected 2", cnt_zero); end
        clr_stats  = 1'b1;
        in_valid   = 1'b1;
        in_product = 16'h7FC1;
        tick();
        clr_stats = 1'b0;
        in_valid  = 1'b0;
        drain();
        @(negedge clk);
        checks += 3;
        if (cnt_nan !== 4'd1)  begin errors++; $display("FAIL clr_accept_nan: got %0d expected 1", cnt_nan); end
        if (cnt_zero !== 4'd0) begin errors++; $display("FAIL clr_accept_zero: got %0d expected 0", cnt_zero); end
        if (cnt_inf !== 4'd0)  begin errors++; $display("FAIL clr_accept_inf: got %0d expected 0", cnt_inf); end
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt_nan !== 4'd0)  begin errors++; $display("FAIL clr_only_nan: got %0d expected 0", cnt_nan); end
    endtask

    task automatic test_async_reset();
        words[0] = 16'h4400; words[1] = 16'h0000; words[2] = 16'h4402;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_product = words[i];
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (level !== 3'd3)    begin errors++; $display("FAIL pre_rst_level: got %0d expected 3", level); end
        if (cnt_zero !== 4'd1) begin errors++; $display("FAIL pre_rst_cnt_zero: got %0d expected 1", cnt_zero); end
        #2 rst = 1'b1;
        #1;
        checks += 6;
        if (level !== 3'd0)        begin errors++; $display("FAIL arst_level: got %0d expected 0", level); end
        if (out_valid !== 1'b0)    begin errors++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
        if (out_product !== 16'h0) begin errors++; $display("FAIL arst_out_product: got %h expected 0000", out_product); end
        if (out_class !== 3'd0)    begin errors++; $display("FAIL arst_out_class: got %0d expected 0", out_class); end
        if (in_ready !== 1'b0)     begin errors++; $display("FAIL arst_in_ready: got %b expected 0", in_ready); end
        if (cnt_zero !== 4'd0)     begin errors++; $display("FAIL arst_cnt_zero: got %0d expected 0", cnt_zero); end
        @(posedge clk); #1; rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %b expected 0", out_valid); end
        if (level !== 3'd0)     begin errors++; $display("FAIL post_rst_level: got %0d expected 0", level); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_pop();
        test_back_to_back();
        test_classify();
        test_saturate();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
